// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter.
// Bytes written through a one-cycle strobe are queued in a small circular FIFO.
// A bit-timing state machine drains the FIFO and shifts each byte out LSB-first.
// Frames are sent back to back, with no idle gap, while bytes remain queued.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          tx
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [BW-1:0] BAUD_LOAD  = BW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   level_next;

    logic [1:0]    state;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_idx;
    logic [BW-1:0] baud_cnt;

    logic          push;
    logic          pop;
    logic          baud_done;

    // The registered full flag gates writes, so a write during a full-FIFO pop
    // is still dropped.
    assign baud_done = (baud_cnt == '0);
    assign push      = wr_en && !full;
    assign pop       = (level != '0) &&
                       ((state == S_IDLE) || ((state == S_STOP) && baud_done));
    assign busy      = (state != S_IDLE) || (level != '0);

    // Occupancy after this edge: a simultaneous push and pop leave it unchanged.
    always_comb begin
        level_next = level;
        if (push && !pop) begin
            level_next = level + (AW + 1)'(1);
        end else if (pop && !push) begin
            level_next = level - (AW + 1)'(1);
        end
    end

    // Byte storage; the contents need no reset because the occupancy count guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; full and level stay registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_next;
            full  <= (level_next == LEVEL_FULL);
        end
    end

    // Frame sequencer: each bit lasts one baud countdown, and tx is driven from a flop so it never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tx        <= 1'b1;
            shift_reg <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        bit_idx   <= '0;
                        baud_cnt  <= BAUD_LOAD;
                        state     <= S_START;
                        tx        <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_LOAD;
                        state    <= S_DATA;
                        tx       <= shift_reg[0];
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= BAUD_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx   <= bit_idx + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            tx        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_done) begin
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            bit_idx   <= '0;
                            baud_cnt  <= BAUD_LOAD;
                            state     <= S_START;
                            tx        <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for the buffered UART transmitter.
// Accepted bytes are queued when written. A line receiver decodes tx and checks
// each frame against the head of the queue.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full;
    logic       busy;
    logic       tx;
    logic [2:0] level;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    bit         rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_byte = 8'h00;

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .full   (full),
        .level  (level),
        .busy   (busy),
        .tx     (tx)
    );

    // 100 MHz style free-running clock.
    always #5 clk = ~clk;

    // Rising-edge count, used to time events relative to the write edge.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Called at a falling edge; holds the strobe across one rising edge and returns at the next falling edge.
    task automatic applyStimulus(input logic [7:0] b, input bit accept);
        wr_en   = 1'b1;
        wr_data = b;
        if (accept) exp_q.push_back(b);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic waitCycle(input int target);
        while (cycle < target) @(negedge clk);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 1000 && (exp_q.size() != 0 || busy || rx_active); i++) @(negedge clk);
        checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
        checkOutput("drain_busy", 32'(busy), 32'd0);
    endtask

    // Line receiver: samples each bit mid-period on falling edges and scores the decoded byte.
    always @(negedge clk) begin
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_cnt    = 0;
                start_q.push_back(cycle);
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % CPB) == (CPB / 2)) begin
                if (rx_cnt / CPB == 0) begin
                    checkOutput("start_bit", 32'(tx), 32'd0);
                end else if (rx_cnt / CPB <= 8) begin
                    rx_byte[rx_cnt / CPB - 1] = tx;
                end else begin
                    logic [31:0] want;
                    checkOutput("stop_bit", 32'(tx), 32'd1);
                    if (exp_q.size() > 0) want = 32'(exp_q.pop_front());
                    else want = 32'h1FF;
                    checkOutput("rx_byte", 32'(rx_byte), want);
                    rx_active = 1'b0;
                end
            end
        end
    end

    // Abort cleanly if the run ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios driving the scoreboard.
    initial begin
        int n0;
        int low_seen;
        int offs[2];
        logic [31:0] pre_tx[2];

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", 32'(tx), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        #2 rst = 1'b0;
        low_seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen++;
        end
        checkOutput("idle_tx_low_count", 32'(low_seen), 32'd0);

        // Single byte 0xA5
        start_q.delete();
        applyStimulus(8'hA5, 1'b1);
        n0 = cycle;
        checkOutput("single_level_after_write", 32'(level), 32'd1);
        checkOutput("single_busy_after_write", 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput("single_tx_start", 32'(tx), 32'd0);
        checkOutput("single_level_after_pop", 32'(level), 32'd0);
        waitCycle(n0 + 40);
        checkOutput("single_busy_last_stop", 32'(busy), 32'd1);
        checkOutput("single_tx_last_stop", 32'(tx), 32'd1);
        waitCycle(n0 + 41);
        checkOutput("single_busy_done", 32'(busy), 32'd0);
        waitDrain();
        checkOutput("single_start_offset", (start_q.size() > 0) ? 32'(start_q[0] - n0) : 32'hFFFF_FFFF, 32'd1);

        // Back-to-back 0x00, 0xFF
        repeat (3) @(negedge clk);
        start_q.delete();
        applyStimulus(8'h00, 1'b1);
        n0 = cycle;
        applyStimulus(8'hFF, 1'b1);
        checkOutput("b2b_level", 32'(level), 32'd1);
        waitDrain();
        checkOutput("b2b_frames", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2) begin
            checkOutput("b2b_first_offset", 32'(start_q[0] - n0), 32'd1);
            checkOutput("b2b_gap", 32'(start_q[1] - start_q[0]), 32'd40);
        end

        // Overflow, then a write on the full-FIFO pop edge
        repeat (3) @(negedge clk);
        start_q.delete();
        applyStimulus(8'h01, 1'b1);
        n0 = cycle;
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h04, 1'b1);
        applyStimulus(8'h05, 1'b1);
        checkOutput("ovf_full_at_4", 32'(full), 32'd1);
        checkOutput("ovf_level_at_4", 32'(level), 32'd4);
        applyStimulus(8'h06, 1'b0);
        checkOutput("ovf_full_after_drop", 32'(full), 32'd1);
        checkOutput("ovf_level_after_drop", 32'(level), 32'd4);
        waitCycle(n0 + 40);
        checkOutput("ovf_full_before_pop", 32'(full), 32'd1);
        applyStimulus(8'h77, 1'b0);
        checkOutput("pushpop_level", 32'(level), 32'd3);
        checkOutput("pushpop_full", 32'(full), 32'd0);
        waitDrain();
        checkOutput("ovf_frames", 32'(start_q.size()), 32'd5);

        // Reset mid-frame: during data bit 3 (a one), then during the start bit
        offs[0]   = 18;
        offs[1]   = 2;
        pre_tx[0] = 32'd1;
        pre_tx[1] = 32'd0;
        for (int k = 0; k < 2; k++) begin
            repeat (3) @(negedge clk);
            applyStimulus(8'h3C, 1'b1);
            n0 = cycle;
            waitCycle(n0 + offs[k]);
            checkOutput("midrst_pre_tx", 32'(tx), pre_tx[k]);
            #2 rst = 1'b1;
            exp_q.delete();
            #1;
            checkOutput("midrst_tx", 32'(tx), 32'd1);
            checkOutput("midrst_busy", 32'(busy), 32'd0);
            checkOutput("midrst_level", 32'(level), 32'd0);
            checkOutput("midrst_full", 32'(full), 32'd0);
            repeat (2) @(negedge clk);
            #2 rst = 1'b0;
            @(negedge clk);
            start_q.delete();
            applyStimulus(8'h81, 1'b1);
            n0 = cycle;
            checkOutput("postrst_level", 32'(level), 32'd1);
            waitDrain();
            checkOutput("postrst_frames", 32'(start_q.size()), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
